fetch_queue_unit: RTL

Parametrised instruction-fetch front end sitting between the byte-wide memory controller and the dispatch/ROB stage. It assembles 32-bit instructions from four pipelined byte reads and predicts the next PC: JAL is always taken, and conditional branches are predicted by a 2-bit BHT trained from commit. Fetched words are buffered in a DEPTH-entry FIFO tagged with PC and predicted PC. A commit-time flush redirects fetch.

---
 rtl/fetch_queue_unit_if.sv | 34 +++
 rtl/fetch_queue_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus bundle: byte-wide memory read port plus the fetched-instruction
// queue head presented to dispatch. Master is the fetch unit, slave is its environment.
interface fetch_queue_unit_if #(
  parameter int QUEUE_DEPTH = 16
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_grant;
  logic [7:0]    mem_din;

  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pred_pc;
  logic          out_pred_taken;
  logic [CW-1:0] queue_count;

  modport master (
    output mem_req, mem_addr,
    input  mem_grant, mem_din,
    input  out_ready,
    output out_valid, out_instr, out_pc, out_pred_pc, out_pred_taken, queue_count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_grant, mem_din,
    output out_ready,
    input  out_valid, out_instr, out_pc, out_pred_pc, out_pred_taken, queue_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: assembles 32-bit words from four byte reads, predicts the
// next PC (JAL taken, branches via a 2-bit BHT), and queues {instr, pc, pred_pc, taken}.
module fetch_queue_unit #(
  parameter int QUEUE_DEPTH = 16,
  parameter int BHT_ENTRIES = 64,
  parameter bit PRED_EN     = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic [31:0]        flush_pc_in,
  input  logic               bht_upd_valid,
  input  logic [31:0]        bht_upd_pc,
  input  logic               bht_upd_taken,
  fetch_queue_unit_if.master fq
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {ST_IDLE, ST_FETCH} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        taken;
  } fq_entry_t;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [2:0]      iss_cnt_q, iss_cnt_d;
  logic [1:0]      rcv_cnt_q, rcv_cnt_d;
  logic [2:0][7:0] lane_q, lane_d;
  logic            gnt_dly_q, gnt_dly_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  fq_entry_t       fifo_q [QUEUE_DEPTH];
  logic [1:0]      bht_q  [BHT_ENTRIES];

  logic            mem_req, granted, word_done, push, pop, out_valid;
  logic [31:0]     word, j_imm, b_imm, pred_pc;
  logic            pred_taken;
  logic [1:0]      bht_ctr;
  fq_entry_t       push_entry, head;

  // Memory side: one read per cycle until all four byte addresses are issued.
  assign mem_req   = rdy_in && (state_q == ST_FETCH) && !iss_cnt_q[2];
  assign granted   = mem_req && fq.mem_grant;
  assign word_done = (state_q == ST_FETCH) && gnt_dly_q && (rcv_cnt_q == 2'd3);
  assign word      = {fq.mem_din, lane_q[2], lane_q[1], lane_q[0]};

  assign out_valid = (count_q != '0);
  assign push      = rdy_in && !flush_in && word_done;
  assign pop       = rdy_in && !flush_in && out_valid && fq.out_ready;

  // Prediction uses the word as it completes, so lane 3 comes straight off mem_din.
  assign j_imm   = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
  assign b_imm   = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
  assign bht_ctr = bht_q[fetch_pc_q[BW+1:2]];

  always_comb begin
    pred_pc    = fetch_pc_q + 32'd4;
    pred_taken = 1'b0;
    if (word[6:0] == OP_JAL) begin
      pred_pc    = fetch_pc_q + j_imm;
      pred_taken = 1'b1;
    end else if (PRED_EN && (word[6:0] == OP_BRANCH) && bht_ctr[1]) begin
      pred_pc    = fetch_pc_q + b_imm;
      pred_taken = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    lane_d     = lane_q;
    gnt_dly_d  = gnt_dly_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d    = ST_IDLE;
        fetch_pc_d = flush_pc_in;
        iss_cnt_d  = '0;
        rcv_cnt_d  = '0;
        gnt_dly_d  = 1'b0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        count_d    = '0;
      end else begin
        gnt_dly_d = granted;
        case (state_q)
          // Only one word is ever in flight, so checking occupancy here reserves its slot.
          ST_IDLE: begin
            if (count_q < CW'(QUEUE_DEPTH)) begin
              state_d   = ST_FETCH;
              iss_cnt_d = '0;
              rcv_cnt_d = '0;
            end
          end
          ST_FETCH: begin
            if (granted) iss_cnt_d = iss_cnt_q + 3'd1;
            if (gnt_dly_q) begin
              rcv_cnt_d = rcv_cnt_q + 2'd1;
              if (rcv_cnt_q != 2'd3) lane_d[rcv_cnt_q] = fq.mem_din;
            end
            if (word_done) begin
              state_d    = ST_IDLE;
              fetch_pc_d = pred_pc;
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      lane_q     <= '0;
      gnt_dly_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      lane_q     <= lane_d;
      gnt_dly_q  <= gnt_dly_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: every output is masked while the queue is empty.
  assign push_entry = '{instr: word, pc: fetch_pc_q, pred_pc: pred_pc, taken: pred_taken};

  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign head               = fifo_q[rd_ptr_q];
  assign fq.mem_req         = mem_req;
  assign fq.mem_addr        = fetch_pc_q + {29'd0, iss_cnt_q};
  assign fq.out_valid       = out_valid;
  assign fq.out_instr       = out_valid ? head.instr   : '0;
  assign fq.out_pc          = out_valid ? head.pc      : '0;
  assign fq.out_pred_pc     = out_valid ? head.pred_pc : '0;
  assign fq.out_pred_taken  = out_valid && head.taken;
  assign fq.queue_count     = count_q;

  // Branch history: saturating 2-bit counters trained at commit, weakly not-taken at reset.
  logic [BW-1:0] upd_idx;
  logic [1:0]    upd_ctr, upd_nxt;
  logic          unused_upd_bits;

  assign upd_idx         = bht_upd_pc[BW+1:2];
  assign upd_ctr         = bht_q[upd_idx];
  assign unused_upd_bits = ^{bht_upd_pc[31:BW+2], bht_upd_pc[1:0]};

  always_comb begin
    upd_nxt = upd_ctr;
    if (bht_upd_taken && (upd_ctr != 2'd3))       upd_nxt = upd_ctr + 2'd1;
    else if (!bht_upd_taken && (upd_ctr != 2'd0)) upd_nxt = upd_ctr - 2'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy_in && bht_upd_valid) begin
      bht_q[upd_idx] <= upd_nxt;
    end
  end
endmodule
